// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction, load-hold across stalls
// and a retired-instruction counter for the 5-stage RV32I core.
module mem_wb_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      MEM_valid,
    input  logic                      MEM_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] MEM_rd_addr,
    input  logic [DATA_WIDTH-1:0]     MEM_rd_data,
    input  logic                      MEM_DMread_sel,
    input  logic [2:0]                MEM_funct3,
    input  logic [1:0]                MEM_byte_off,
    input  logic [DATA_WIDTH-1:0]     DM_out,
    output logic                      WB_valid,
    output logic                      WB_reg_write,
    output logic [REG_ADDR_WIDTH-1:0] WB_rd_addr,
    output logic [DATA_WIDTH-1:0]     WB_rd_data,
    output logic [31:0]               WB_instret
);

    typedef enum logic {LIVE = 1'b0, HOLD = 1'b1} hold_state_t;

    hold_state_t               state, state_next;
    logic                      capture_hold;
    logic [DATA_WIDTH-1:0]     hold_word;

    logic                      valid_q;
    logic                      reg_write_q;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
    logic [DATA_WIDTH-1:0]     rd_data_q;
    logic                      load_q;
    logic [2:0]                funct3_q;
    logic [1:0]                byte_off_q;
    logic [31:0]               instret_q;

    logic [DATA_WIDTH-1:0]     load_word;
    logic [7:0]                byte_sel;
    logic [15:0]               half_sel;
    logic [DATA_WIDTH-1:0]     load_value;

    // Bubble clears only the control fields; data fields are don't-care.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
            load_q      <= 1'b0;
            funct3_q    <= 3'b000;
            byte_off_q  <= 2'b00;
        end else if (!stall) begin
            if (flush) begin
                valid_q     <= 1'b0;
                reg_write_q <= 1'b0;
                rd_addr_q   <= '0;
                load_q      <= 1'b0;
            end else begin
                valid_q     <= MEM_valid;
                reg_write_q <= MEM_reg_write;
                rd_addr_q   <= MEM_rd_addr;
                rd_data_q   <= MEM_rd_data;
                load_q      <= MEM_DMread_sel;
                funct3_q    <= MEM_funct3;
                byte_off_q  <= MEM_byte_off;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LIVE;
            hold_word <= '0;
        end else begin
            state <= state_next;
            if (capture_hold) begin
                hold_word <= DM_out;
            end
        end
    end

    // DM_out is only valid in the first WB cycle, so a stalled load keeps its word.
    always_comb begin
        state_next   = state;
        capture_hold = 1'b0;
        case (state)
            LIVE: begin
                if (stall && valid_q && load_q) begin
                    capture_hold = 1'b1;
                    state_next   = HOLD;
                end
            end
            HOLD: begin
                if (!stall) begin
                    state_next = LIVE;
                end
            end
            default: state_next = LIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (!stall && valid_q) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign load_word = (state == HOLD) ? hold_word : DM_out;
    assign byte_sel  = 8'(load_word >> {byte_off_q, 3'b000});
    assign half_sel  = 16'(load_word >> {byte_off_q[1], 4'b0000});

    always_comb begin
        load_value = '0;
        case (funct3_q)
            3'b000:  load_value = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_value = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b010:  load_value = load_word;
            3'b100:  load_value = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            3'b101:  load_value = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_value = '0;
        endcase
    end

    assign WB_valid     = valid_q;
    assign WB_reg_write = reg_write_q && valid_q && (rd_addr_q != '0);
    assign WB_rd_addr   = rd_addr_q;
    assign WB_rd_data   = load_q ? load_value : rd_data_q;
    assign WB_instret   = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: load-extension table, hand sequences for
// reset/stall/flush/x0/wrap, and a randomized run against a reference model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        MEM_valid = 1'b0;
    logic        MEM_reg_write = 1'b0;
    logic [4:0]  MEM_rd_addr = '0;
    logic [31:0] MEM_rd_data = '0;
    logic        MEM_DMread_sel = 1'b0;
    logic [2:0]  MEM_funct3 = '0;
    logic [1:0]  MEM_byte_off = '0;
    logic [31:0] DM_out = '0;
    logic        WB_valid;
    logic        WB_reg_write;
    logic [4:0]  WB_rd_addr;
    logic [31:0] WB_rd_data;
    logic [31:0] WB_instret;

    int n_cmp = 0;
    int n_err = 0;

    mem_wb_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .MEM_valid(MEM_valid), .MEM_reg_write(MEM_reg_write),
        .MEM_rd_addr(MEM_rd_addr), .MEM_rd_data(MEM_rd_data),
        .MEM_DMread_sel(MEM_DMread_sel), .MEM_funct3(MEM_funct3),
        .MEM_byte_off(MEM_byte_off), .DM_out(DM_out),
        .WB_valid(WB_valid), .WB_reg_write(WB_reg_write),
        .WB_rd_addr(WB_rd_addr), .WB_rd_data(WB_rd_data),
        .WB_instret(WB_instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] dm;
        logic [31:0] exp;
    } load_vec_t;

    load_vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                         input logic [31:0] d, input logic ld,
                         input logic [2:0] f3, input logic [1:0] off);
        MEM_valid      = v;
        MEM_reg_write  = rw;
        MEM_rd_addr    = rd;
        MEM_rd_data    = d;
        MEM_DMread_sel = ld;
        MEM_funct3     = f3;
        MEM_byte_off   = off;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b1; flush = 1'b0;
        drive(1'b1, 1'b1, 5'd9, 32'hAAAA_5555, 1'b1, 3'b010, 2'b00);
        tick();
        tick();
        rst = 1'b0; stall = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b000, 2'b00);
    endtask

    // Reference load extraction from byte/halfword arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) % 256;
        h = (w >> (16 * (off / 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    // Reference model state: what WB currently shows.
    logic        m_valid, m_rw, m_load, m_frozen;
    logic [4:0]  m_rd;
    logic [31:0] m_data, m_word, m_instret;
    logic [2:0]  m_f3;
    logic [1:0]  m_off;

    initial begin
        vecs[0]  = '{3'b000, 2'd0, 32'h80F1_7F82, 32'hFFFF_FF82};
        vecs[1]  = '{3'b000, 2'd1, 32'h80F1_7F82, 32'h0000_007F};
        vecs[2]  = '{3'b100, 2'd3, 32'h80F1_7F82, 32'h0000_0080};
        vecs[3]  = '{3'b001, 2'd2, 32'h80F1_7F82, 32'hFFFF_80F1};
        vecs[4]  = '{3'b101, 2'd0, 32'h80F1_7F82, 32'h0000_7F82};
        vecs[5]  = '{3'b010, 2'd0, 32'h80F1_7F82, 32'h80F1_7F82};
        vecs[6]  = '{3'b001, 2'd3, 32'h80F1_7F82, 32'hFFFF_80F1};
        vecs[7]  = '{3'b101, 2'd2, 32'h80F1_7F82, 32'h0000_80F1};
        vecs[8]  = '{3'b100, 2'd2, 32'h80F1_7F82, 32'h0000_00F1};
        vecs[9]  = '{3'b011, 2'd0, 32'h80F1_7F82, 32'h0000_0000};
        vecs[10] = '{3'b110, 2'd1, 32'h80F1_7F82, 32'h0000_0000};
        vecs[11] = '{3'b001, 2'd1, 32'h80F1_7F82, 32'h0000_7F82};
        vecs[12] = '{3'b010, 2'd3, 32'h1234_5678, 32'h1234_5678};

        // Reset with stall and valid input held high.
        do_reset();
        #1;
        chk("rst_valid", 32'(WB_valid), 32'd0);
        chk("rst_rw", 32'(WB_reg_write), 32'd0);
        chk("rst_rd", 32'(WB_rd_addr), 32'd0);
        chk("rst_data", WB_rd_data, 32'd0);
        chk("rst_instret", WB_instret, 32'd0);
        drive(1'b1, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 3'b000, 2'b00);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b000, 2'b00);
        #1;
        chk("add_rw", 32'(WB_reg_write), 32'd1);
        chk("add_rd", 32'(WB_rd_addr), 32'd5);
        chk("add_data", WB_rd_data, 32'h0000_1234);
        chk("add_instret0", WB_instret, 32'd0);
        tick();
        #1;
        chk("add_instret1", WB_instret, 32'd1);

        // Load extension table.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, 1'b1, 5'd1, 32'hCAFE_0000, 1'b1, vecs[i].f3, vecs[i].off);
            tick();
            DM_out = vecs[i].dm;
            #1;
            chk($sformatf("load_vec%0d", i), WB_rd_data, vecs[i].exp);
        end

        // Stall during a load: the first-cycle memory word must persist.
        do_reset();
        drive(1'b1, 1'b1, 5'd7, 32'h0, 1'b1, 3'b010, 2'b00);
        tick();
        drive(1'b1, 1'b1, 5'd9, 32'h0000_0099, 1'b0, 3'b000, 2'b00);
        DM_out = 32'hDEAD_BEEF;
        stall = 1'b1;
        #1;
        chk("stl_first", WB_rd_data, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            tick();
            DM_out = 32'h1111_1111;
            if (i == 2) stall = 1'b0;
            #1;
            chk($sformatf("stl_hold%0d", i), WB_rd_data, 32'hDEAD_BEEF);
            chk($sformatf("stl_rd%0d", i), 32'(WB_rd_addr), 32'd7);
            chk($sformatf("stl_ret%0d", i), WB_instret, 32'd0);
        end
        tick();
        drive(1'b1, 1'b1, 5'd8, 32'h0, 1'b1, 3'b010, 2'b00);
        #1;
        chk("stl_rel_ret", WB_instret, 32'd1);
        chk("stl_rel_data", WB_rd_data, 32'h0000_0099);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b000, 2'b00);
        DM_out = 32'h2222_3333;
        #1;
        chk("stl_live", WB_rd_data, 32'h2222_3333);
        chk("stl_live_ret", WB_instret, 32'd2);

        // Flush, then flush under stall.
        do_reset();
        drive(1'b1, 1'b1, 5'd3, 32'h0000_000A, 1'b0, 3'b000, 2'b00);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b1, 1'b1, 5'd4, 32'h0000_000B, 1'b0, 3'b000, 2'b00);
        #1;
        chk("fl_valid", 32'(WB_valid), 32'd0);
        chk("fl_rw", 32'(WB_reg_write), 32'd0);
        chk("fl_ret", WB_instret, 32'd1);
        tick();
        flush = 1'b1; stall = 1'b1;
        tick();
        #1;
        chk("flst_valid", 32'(WB_valid), 32'd1);
        chk("flst_rd", 32'(WB_rd_addr), 32'd4);
        chk("flst_data", WB_rd_data, 32'h0000_000B);
        chk("flst_ret", WB_instret, 32'd1);
        stall = 1'b0;
        tick();
        flush = 1'b0;
        #1;
        chk("flrel_valid", 32'(WB_valid), 32'd0);
        chk("flrel_rw", 32'(WB_reg_write), 32'd0);
        chk("flrel_ret", WB_instret, 32'd2);

        // Write to x0 is suppressed but still retires.
        do_reset();
        drive(1'b1, 1'b1, 5'd0, 32'h0000_0055, 1'b0, 3'b000, 2'b00);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b000, 2'b00);
        #1;
        chk("x0_valid", 32'(WB_valid), 32'd1);
        chk("x0_rw", 32'(WB_reg_write), 32'd0);
        chk("x0_data", WB_rd_data, 32'h0000_0055);
        tick();
        #1;
        chk("x0_ret", WB_instret, 32'd1);

        // Counter wrap.
        do_reset();
        drive(1'b1, 1'b1, 5'd2, 32'h1, 1'b0, 3'b000, 2'b00);
        tick();
        force dut.instret_q = 32'hFFFF_FFFE;
        #1;
        release dut.instret_q;
        tick();
        #1;
        chk("wrap0", WB_instret, 32'hFFFF_FFFF);
        tick();
        #1;
        chk("wrap1", WB_instret, 32'h0000_0000);
        tick();
        #1;
        chk("wrap2", WB_instret, 32'h0000_0001);

        // Randomized run against the reference model.
        do_reset();
        m_valid = 0; m_rw = 0; m_rd = 0; m_data = 0; m_load = 0;
        m_f3 = 0; m_off = 0; m_frozen = 0; m_word = 0; m_instret = 0;
        for (int c = 0; c < 400; c++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            drive(1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)));
            DM_out = $urandom;
            #1;
            chk("rnd_valid", 32'(WB_valid), 32'(m_valid));
            chk("rnd_rw", 32'(WB_reg_write), 32'(m_rw && m_valid && (m_rd != 0)));
            chk("rnd_rd", 32'(WB_rd_addr), 32'(m_rd));
            chk("rnd_ret", WB_instret, m_instret);
            if (m_valid) begin
                chk("rnd_data", WB_rd_data,
                    m_load ? ref_load(m_f3, m_off, m_frozen ? m_word : DM_out) : m_data);
            end
            if (stall) begin
                if (m_valid && m_load && !m_frozen) begin
                    m_frozen = 1;
                    m_word   = DM_out;
                end
            end else begin
                if (m_valid) m_instret = m_instret + 1;
                m_frozen = 0;
                if (flush) begin
                    m_valid = 0; m_rw = 0; m_rd = 0; m_load = 0;
                end else begin
                    m_valid = MEM_valid; m_rw = MEM_reg_write; m_rd = MEM_rd_addr;
                    m_data = MEM_rd_data; m_load = MEM_DMread_sel;
                    m_f3 = MEM_funct3; m_off = MEM_byte_off;
                end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
